// File: rtl/hex_seg_serial_driver.sv
// Hex-to-7-segment frame encoder with blink and a serial shift-register driver.
// Optional HEXSEG_AUTO_REFRESH_EN: retransmit automatically on input or blink change.
module hex_seg_serial_driver #(
  parameter int DIGITS   = 8,
  parameter int SCLK_DIV = 2,
  parameter int BLINK_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     les,
  input  logic [DIGITS-1:0]     point,
  output logic                  busy,
  output logic                  done,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_latch,
  output logic                  seg_clrn
);

  localparam int N  = 8 * DIGITS;
  localparam int DW = $clog2(SCLK_DIV) + 1;
  localparam int BW = $clog2(N);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t             state;
  logic [N-1:0]       frame;
  logic [N-1:0]       enc;
  logic [DW-1:0]      divcnt;
  logic [BW-1:0]      bitcnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               flash;
  logic               div_end;
  logic               req;

  // Active-low {a,b,c,d,e,f,g} pattern for one hex value.
  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign flash    = blink_cnt[BLINK_W-1];
  assign div_end  = (divcnt == DIV_LAST);
  assign seg_sout = frame[N-1];

  // Build the frame: leftmost digit lands in the top byte so it goes out first.
  always_comb begin
    enc = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (les[DIGITS-1-k] && flash)
        enc[N-1-8*k -: 8] = 8'hFF;
      else
        enc[N-1-8*k -: 8] = {seg7(hexs[4*(DIGITS-1-k) +: 4]),
                             ~point[DIGITS-1-k]};
    end
  end

  // Free-running blink timebase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blink_cnt <= '0;
    else
      blink_cnt <= blink_cnt + 1'b1;
  end

`ifdef HEXSEG_AUTO_REFRESH_EN
  logic [4*DIGITS-1:0] cap_hexs;
  logic [DIGITS-1:0]   cap_les;
  logic [DIGITS-1:0]   cap_point;
  logic                cap_flash;

  // Any difference from the last sent inputs stays pending until serviced.
  assign req = start
             | (hexs != cap_hexs)
             | (les != cap_les)
             | (point != cap_point)
             | (flash != cap_flash);

  // Remember what the last accepted frame was built from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_hexs  <= '0;
      cap_les   <= '0;
      cap_point <= '0;
      cap_flash <= 1'b0;
    end else if (state == IDLE && req) begin
      cap_hexs  <= hexs;
      cap_les   <= les;
      cap_point <= point;
      cap_flash <= flash;
    end
  end
`else
  assign req = start;
`endif

  // Transfer sequencer: clock out N bits, then pulse the chain latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_latch <= 1'b0;
      seg_clrn  <= 1'b0;
      frame     <= '0;
      divcnt    <= '0;
      bitcnt    <= '0;
    end else begin
      seg_clrn <= 1'b1;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            frame   <= enc;
            bitcnt  <= BIT_LAST;
            divcnt  <= '0;
            busy    <= 1'b1;
            seg_clk <= 1'b0;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_end) begin
            divcnt  <= '0;
            seg_clk <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_end) begin
            divcnt  <= '0;
            seg_clk <= 1'b0;
            frame   <= {frame[N-2:0], 1'b0};
            if (bitcnt == '0) begin
              seg_latch <= 1'b1;
              state     <= LATCH;
            end else begin
              bitcnt <= bitcnt - 1'b1;
              state  <= SHIFT_LO;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_end) begin
            divcnt    <= '0;
            seg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
